// File: rtl/rv_pkg.sv
// rv_pkg: shared types and constants for the instruction fetch stage
package rv_pkg;

    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        FS_RUN,
        FS_HALT
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small registered FIFO of {pc, instr} entries with single-cycle flush
module fetch_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  fetch_entry_t data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic [CW-1:0] count_o,
    output logic         empty_o
);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  last_q;
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;

    assign count_o = cnt_q;
    assign empty_o = cnt_q == '0;
    assign head_o  = empty_o ? last_q : mem_q[rd_q];

    // Storage and pointers; flush drops all entries but leaves the read slot untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= rd_q;
            cnt_q <= '0;
        end else begin
            if (push_i) mem_q[wr_q] <= data_i;
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // Remember the most recent head so the output holds steady while empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= '0;
        else if (!empty_o) last_q <= mem_q[rd_q];
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, reads the instruction ROM and buffers fetched words toward decode
module fetch_unit
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = rv_pkg::RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        fetch_fault
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic          push, pop, fifo_empty;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  head;

    assign imem_addr   = pc_q;
    assign out_valid   = ~fifo_empty;
    assign out_pc      = head.pc;
    assign out_instr   = head.instr;
    assign fetch_fault = state_q == FS_HALT;
    assign pop         = out_valid & out_ready;
    assign push        = (state_q == FS_RUN) & ~redirect_valid & ((fifo_count < CW'(FIFO_DEPTH)) | pop);

    // Next PC and run/halt state; a redirect wins over sequential fetch
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            state_d = (redirect_pc[1:0] != 2'b00) ? FS_HALT : FS_RUN;
        end else if (push) begin
            pc_d = pc_q + INSTR_BYTES;
        end
    end

    // PC and fault state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FS_RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  ('{pc: pc_q, instr: imem_data}),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .head_o  (head),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random checks of fetch_unit against a queue-based reference model
module tb_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr, imem_data, redirect_pc = '0, out_pc, out_instr;
    logic        redirect_valid = 1'b0, out_ready = 1'b0, out_valid, fetch_fault;

    int total = 0;
    int bad = 0;

    logic [63:0] q[$];
    logic [31:0] m_pc = '0;
    logic        m_halt = 1'b0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .fetch_fault    (fetch_fault)
    );

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0010_0093;
            32'h4:   return 32'h0020_8113;
            32'h8:   return 32'h0000_006F;
            32'h40:  return 32'h0000_0013;
            default: return a ^ 32'hC3A5_0F01;
        endcase
    endfunction

    assign imem_data = rom(imem_addr);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_step(input logic rv, input logic [31:0] rpc, input logic rdy);
        int  sz = q.size();
        bit  pop = sz > 0 && rdy;
        if (rv) begin
            q.delete();
            m_pc   = rpc;
            m_halt = rpc[1:0] != 2'b00;
        end else begin
            if (pop) void'(q.pop_front());
            if (!m_halt && (sz < DEPTH || pop)) begin
                q.push_back({m_pc, rom(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic compare_model();
        check_eq("valid", out_valid, q.size() > 0);
        if (q.size() > 0) begin
            check_eq("pc", out_pc, q[0][63:32]);
            check_eq("instr", out_instr, q[0][31:0]);
        end
        check_eq("imem_addr", imem_addr, m_pc);
        check_eq("fault", fetch_fault, m_halt);
    endtask

    task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        @(posedge clk);
        model_step(rv, rpc, rdy);
        #1;
        compare_model();
        redirect_valid = 1'b0;
    endtask

    task automatic expect_head(input string tag, input logic [31:0] pc, input logic [31:0] instr);
        check_eq({tag, "_valid"}, out_valid, 1'b1);
        check_eq({tag, "_pc"}, out_pc, pc);
        check_eq({tag, "_instr"}, out_instr, instr);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_valid", out_valid, 1'b0);
        check_eq("rst_fault", fetch_fault, 1'b0);
        check_eq("rst_pc", out_pc, 32'h0);
        check_eq("rst_instr", out_instr, 32'h0);
        check_eq("rst_addr", imem_addr, 32'h0);
        q.delete();
        m_pc   = '0;
        m_halt = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] pick_target();
        logic [31:0] t;
        case ($urandom_range(5))
            0: t = 32'h0;
            1: t = 32'h40;
            2: t = 32'hFFFF_FFF8;
            3: t = 32'h4;
            default: t = $urandom() & 32'hFFFF_FFFC;
        endcase
        if ($urandom_range(4) == 0) t[1:0] = 2'($urandom_range(1, 3));
        return t;
    endfunction

    initial begin
        // reset release and sustained streaming
        do_reset();
        step(1'b0, '0, 1'b1);
        expect_head("t1_0", 32'h0, 32'h0010_0093);
        step(1'b0, '0, 1'b1);
        expect_head("t1_4", 32'h4, 32'h0020_8113);
        step(1'b0, '0, 1'b1);
        expect_head("t1_8", 32'h8, 32'h0000_006F);

        // backpressure: buffer fills, PC stalls, drain without gaps
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0);
        check_eq("t2_addr", imem_addr, 32'h8);
        expect_head("t2_hold", 32'h0, 32'h0010_0093);
        step(1'b0, '0, 1'b1);
        expect_head("t2_4", 32'h4, 32'h0020_8113);
        step(1'b0, '0, 1'b1);
        expect_head("t2_8", 32'h8, 32'h0000_006F);

        // redirect while full
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
        step(1'b1, 32'h40, 1'b0);
        check_eq("t3_flush", out_valid, 1'b0);
        step(1'b0, '0, 1'b1);
        expect_head("t3_40", 32'h40, 32'h0000_0013);

        // misaligned redirect halts, aligned redirect resumes
        step(1'b1, 32'h42, 1'b1);
        check_eq("t4_fault", fetch_fault, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);
        step(1'b1, 32'h4, 1'b1);
        check_eq("t4_clear", fetch_fault, 1'b0);
        step(1'b0, '0, 1'b1);
        expect_head("t4_4", 32'h4, 32'h0020_8113);

        // asynchronous reset mid-stream and while halted
        step(1'b0, '0, 1'b0);
        do_reset();
        step(1'b1, 32'h2, 1'b1);
        do_reset();
        step(1'b0, '0, 1'b1);
        expect_head("t5_0", 32'h0, 32'h0010_0093);

        // PC wrap at the top of the address space
        step(1'b1, 32'hFFFF_FFFC, 1'b1);
        step(1'b0, '0, 1'b1);
        expect_head("t6_top", 32'hFFFF_FFFC, rom(32'hFFFF_FFFC));
        step(1'b0, '0, 1'b1);
        expect_head("t6_wrap", 32'h0, 32'h0010_0093);
        check_eq("t6_fault", fetch_fault, 1'b0);

        // random redirects and backpressure
        for (int i = 0; i < 600; i++) begin
            logic rv = $urandom_range(7) == 0;
            step(rv, rv ? pick_target() : 32'h0, $urandom_range(3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
